// File: rtl/matrix_uart_printer.sv
// matrix_uart_printer
//
// Reads an M x N matrix row-major from a synchronous-read matrix memory and
// prints it as unsigned decimal ASCII over a byte stream toward uart_tx.
// Elements in a row are separated by a single space. Every row ends with
// CR LF. Values above 99999 print as a single '#'.
//
// Byte handshake: a byte moves on the cycle where tx_valid and tx_ready are
// both high. Once tx_valid rises, tx_valid and tx_data stay unchanged until
// that cycle. Only one byte is ever outstanding. The sink may hold tx_ready
// low for any length of time.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  enable; low returns the block to IDLE on the next edge
//   start               request, only looked at in IDLE
//   base_addr           matrix base address, latched on an accepted start
//   dim_m, dim_n        row / column counts, latched on an accepted start
//   rd_en, rd_addr      memory read strobe and address (base + linear index)
//   rd_data             read data, valid one cycle after rd_en
//   tx_valid, tx_data   byte toward uart_tx
//   tx_ready            uart_tx can take a byte
//   busy                high from an accepted start until the DONE/ERR exit
//   done                one-cycle pulse after the last LF is sent
//   err                 one-cycle pulse when the dimensions are illegal
module matrix_uart_printer #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int MAX_DIM = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [2:0]        dim_m,
    input  logic [2:0]        dim_n,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_CONV, S_EMIT,
        S_SEP, S_CR, S_LF, S_DONE, S_ERR
    } state_t;

    localparam logic [2:0]        MAX_D   = 3'(MAX_DIM);
    localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(17'd99999);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [2:0]          m_q, m_d;
    logic [2:0]          n_q, n_d;
    logic [2:0]          row_q, row_d;
    logic [2:0]          col_q, col_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic [2:0]          place_q, place_d;
    logic [3:0]          digit_q, digit_d;
    logic                started_q, started_d;
    logic [7:0]          byte_q, byte_d;
    logic [DATA_W-1:0]   pow_cur;
    logic                dims_bad;

    // Decimal place weight, place 4 = ten-thousands down to place 0 = units.
    function automatic logic [16:0] pow10(input logic [2:0] p);
        case (p)
            3'd4:    pow10 = 17'd10000;
            3'd3:    pow10 = 17'd1000;
            3'd2:    pow10 = 17'd100;
            3'd1:    pow10 = 17'd10;
            default: pow10 = 17'd1;
        endcase
    endfunction

    assign pow_cur  = DATA_W'(pow10(place_q));
    assign dims_bad = (dim_m == 3'd0) || (dim_m > MAX_D) ||
                      (dim_n == 3'd0) || (dim_n > MAX_D);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            idx_q     <= '0;
            m_q       <= '0;
            n_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            val_q     <= '0;
            place_q   <= '0;
            digit_q   <= '0;
            started_q <= 1'b0;
            byte_q    <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            idx_q     <= idx_d;
            m_q       <= m_d;
            n_q       <= n_d;
            row_q     <= row_d;
            col_q     <= col_d;
            val_q     <= val_d;
            place_q   <= place_d;
            digit_q   <= digit_d;
            started_q <= started_d;
            byte_q    <= byte_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        idx_d     = idx_q;
        m_d       = m_q;
        n_d       = n_q;
        row_d     = row_q;
        col_d     = col_q;
        val_d     = val_q;
        place_d   = place_q;
        digit_d   = digit_q;
        started_d = started_q;
        byte_d    = byte_q;

        case (state_q)
            S_IDLE: begin
                if (start && en) begin
                    base_d  = base_addr;
                    m_d     = dim_m;
                    n_d     = dim_n;
                    row_d   = '0;
                    col_d   = '0;
                    idx_d   = '0;
                    state_d = dims_bad ? S_ERR : S_RD_REQ;
                end
            end
            S_RD_REQ: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                val_d     = rd_data;
                place_d   = 3'd4;
                digit_d   = '0;
                started_d = 1'b0;
                if (rd_data > MAX_VAL) begin
                    // Out of printable range: one '#' and no conversion.
                    byte_d  = 8'h23;
                    place_d = 3'd0;
                    state_d = S_EMIT;
                end else begin
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                // Repeated subtraction yields the digit for this place.
                if (val_q >= pow_cur) begin
                    val_d   = val_q - pow_cur;
                    digit_d = digit_q + 4'd1;
                end else if (digit_q != 4'd0 || started_q || place_q == 3'd0) begin
                    byte_d    = 8'h30 + {4'h0, digit_q};
                    started_d = 1'b1;
                    state_d   = S_EMIT;
                end else begin
                    // Leading zero: nothing to print, move to the next place.
                    place_d = place_q - 3'd1;
                    digit_d = '0;
                end
            end
            S_EMIT: begin
                if (tx_ready) begin
                    if (place_q != 3'd0) begin
                        place_d = place_q - 3'd1;
                        digit_d = '0;
                        state_d = S_CONV;
                    end else if (col_q < n_q - 3'd1) begin
                        state_d = S_SEP;
                    end else begin
                        state_d = S_CR;
                    end
                end
            end
            S_SEP: begin
                if (tx_ready) begin
                    col_d   = col_q + 3'd1;
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_RD_REQ;
                end
            end
            S_CR: begin
                if (tx_ready) state_d = S_LF;
            end
            S_LF: begin
                if (tx_ready) begin
                    if (row_q < m_q - 3'd1) begin
                        row_d   = row_q + 3'd1;
                        col_d   = '0;
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_RD_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything else.
        if (!en) state_d = S_IDLE;
    end

    // Strobes are qualified by en so that an abort removes them at once,
    // not only after the state register has returned to IDLE.
    always_comb begin
        rd_en    = en && (state_q == S_RD_REQ);
        rd_addr  = rd_en ? (base_q + idx_q) : '0;
        tx_valid = en && (state_q == S_EMIT || state_q == S_SEP ||
                          state_q == S_CR   || state_q == S_LF);
        busy     = en && (state_q != S_IDLE) && (state_q != S_DONE);
        done     = en && (state_q == S_DONE);
        err      = en && (state_q == S_ERR);
        tx_data  = '0;
        if (tx_valid) begin
            case (state_q)
                S_SEP:   tx_data = 8'h20;
                S_CR:    tx_data = 8'h0D;
                S_LF:    tx_data = 8'h0A;
                default: tx_data = byte_q;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_uart_printer.sv
// Bench for matrix_uart_printer: table of whole-matrix transfers with
// hand-written expected text ('|' stands for CR LF), plus hand-written
// abort and mid-transfer reset sequences.
module tb_matrix_uart_printer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic [8:0]  base_addr;
    logic [2:0]  dim_m;
    logic [2:0]  dim_n;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [31:0] rd_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        err;

    matrix_uart_printer #(.ADDR_W(9), .DATA_W(32), .MAX_DIM(5)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .base_addr(base_addr), .dim_m(dim_m), .dim_n(dim_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .done(done), .err(err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] mem [512];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    logic [8:0]  addr_q [$];
    int cyc = 0;
    int start_cyc, first_rd, first_tx;
    int done_cnt, err_cnt, busy_bad, stall_bad;
    bit ended;
    bit rand_rdy = 1'b0;
    bit pend = 1'b0;
    logic [8:0] pend_addr;
    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_d = 8'h00;

    typedef struct {
        logic [8:0] b;
        logic [2:0] m;
        logic [2:0] n;
        bit         rr;
        bit         ee;
        string      txt;
        int unsigned vals [6];
    } vec_t;
    vec_t vq [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        addr_q.delete();
        start_cyc = -1;
        first_rd  = -1;
        first_tx  = -1;
        done_cnt  = 0;
        err_cnt   = 0;
        busy_bad  = 0;
        stall_bad = 0;
        ended     = 1'b0;
    endtask

    // ---------------- memory model: data one cycle after rd_en ----------------
    always @(posedge clk) begin
        #1;
        rd_data = pend ? mem[pend_addr] : 32'hDEAD_BEEF;
        pend = 1'b0;
    end

    // ---------------- sink: always ready, or ~30% ready ----------------
    always @(posedge clk) begin
        #1;
        tx_ready = rand_rdy ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // ---------------- monitor (sampled mid-cycle) ----------------
    always @(negedge clk) begin
        cyc++;
        if (start && start_cyc < 0) start_cyc = cyc;
        if (rd_en) begin
            addr_q.push_back(rd_addr);
            pend = 1'b1;
            pend_addr = rd_addr;
            if (first_rd < 0) first_rd = cyc;
        end
        if (tx_valid && first_tx < 0) first_tx = cyc;
        if (tx_valid && tx_ready) got_q.push_back(tx_data);
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (start_cyc >= 0 && cyc > start_cyc) begin
            if (!ended) begin
                if (done) begin
                    ended = 1'b1;
                    if (busy) busy_bad++;
                end else if (err) begin
                    ended = 1'b1;
                end else if (!busy) begin
                    busy_bad++;
                end
            end else if (busy) begin
                busy_bad++;
            end
        end
        if (prev_v && !prev_r && en && (!tx_valid || tx_data != prev_d)) stall_bad++;
        prev_v = tx_valid;
        prev_r = tx_ready;
        prev_d = tx_data;
    end

    // ---------------- driver tasks ----------------
    task automatic add_vec(input logic [8:0] b, input logic [2:0] m, input logic [2:0] n,
                           input bit rr, input bit ee, input string txt,
                           input int unsigned v0, input int unsigned v1, input int unsigned v2,
                           input int unsigned v3, input int unsigned v4, input int unsigned v5);
        vec_t v;
        v.b = b; v.m = m; v.n = n; v.rr = rr; v.ee = ee; v.txt = txt;
        v.vals[0] = v0; v.vals[1] = v1; v.vals[2] = v2;
        v.vals[3] = v3; v.vals[4] = v4; v.vals[5] = v5;
        vq.push_back(v);
    endtask

    task automatic drive_start(input logic [8:0] b, input logic [2:0] m, input logic [2:0] n);
        @(posedge clk); #1;
        clear_mon();
        base_addr = b; dim_m = m; dim_n = n; start = 1'b1;
        @(posedge clk); #1;
        // Later changes to these inputs must not affect the running transfer.
        start = 1'b0; base_addr = 9'd300; dim_m = 3'd1; dim_n = 3'd1;
    endtask

    task automatic run_check(input string tag, input logic [8:0] b, input logic [2:0] m,
                             input logic [2:0] n, input bit rr, input bit ee, input string txt);
        int k;
        int nexp;
        logic [8:0] a;
        rand_rdy = rr;
        drive_start(b, m, n);
        k = 0;
        while (done_cnt + err_cnt == 0 && k < 3000) begin
            @(negedge clk); #1;
            k++;
            if (!ee && k == 2) start = 1'b1;   // start while busy: ignored
            if (k == 3) start = 1'b0;
        end
        start = 1'b0;
        check({tag, " finished_in_budget"}, 32'(k < 3000), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        rand_rdy = 1'b0;
        check({tag, " done_pulses"}, 32'(done_cnt), ee ? 32'd0 : 32'd1);
        check({tag, " err_pulses"}, 32'(err_cnt), ee ? 32'd1 : 32'd0);
        exp_q.delete();
        for (int i = 0; i < txt.len(); i++) begin
            if (txt[i] == "|") begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end else begin
                exp_q.push_back(txt[i]);
            end
        end
        check({tag, " byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
                check($sformatf("%s byte[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        nexp = ee ? 0 : int'(m) * int'(n);
        check({tag, " read_count"}, 32'(addr_q.size()), 32'(nexp));
        for (int i = 0; i < nexp; i++) begin
            a = b + 9'(i);
            if (i < addr_q.size())
                check($sformatf("%s rd_addr[%0d]", tag, i), 32'(addr_q[i]), 32'(a));
        end
        if (!ee) begin
            check({tag, " first_rd_latency"}, 32'(first_rd - start_cyc), 32'd1);
            check({tag, " first_tx_latency_ok"}, 32'(first_tx - first_rd <= 47 && first_tx > 0), 32'd1);
        end
        check({tag, " busy_profile_bad"}, 32'(busy_bad), 32'd0);
        if (rr) check({tag, " stall_stability_bad"}, 32'(stall_bad), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " rd_en"}, 32'(rd_en), 32'd0);
        check({tag, " rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, " tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, " tx_data"}, 32'(tx_data), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int k;
        logic [8:0] a;
        rst = 1'b1; en = 1'b1; start = 1'b0;
        base_addr = '0; dim_m = '0; dim_n = '0; tx_ready = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        clear_mon();
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        //       base  m  n  rr ee  expected text
        add_vec(9'd10,  3'd2, 3'd3, 0, 0, "1 2 3|4 5 6|",        1, 2, 3, 4, 5, 6);
        add_vec(9'd20,  3'd1, 3'd1, 0, 0, "0|",                  0, 0, 0, 0, 0, 0);
        add_vec(9'd20,  3'd1, 3'd1, 0, 0, "405|",                405, 0, 0, 0, 0, 0);
        add_vec(9'd20,  3'd1, 3'd1, 0, 0, "99999|",              99999, 0, 0, 0, 0, 0);
        add_vec(9'd20,  3'd1, 3'd1, 0, 0, "#|",                  100000, 0, 0, 0, 0, 0);
        add_vec(9'd40,  3'd2, 3'd2, 1, 0, "7 1000|12 305|",      7, 1000, 12, 305, 0, 0);
        add_vec(9'd510, 3'd2, 3'd2, 0, 0, "10 20|30 40|",        10, 20, 30, 40, 0, 0);
        add_vec(9'd60,  3'd1, 3'd5, 0, 0, "90001 10 100 0 65535|", 90001, 10, 100, 0, 65535, 0);
        add_vec(9'd10,  3'd6, 3'd2, 0, 1, "",                    0, 0, 0, 0, 0, 0);
        add_vec(9'd10,  3'd2, 3'd0, 0, 1, "",                    0, 0, 0, 0, 0, 0);
        add_vec(9'd10,  3'd0, 3'd3, 0, 1, "",                    0, 0, 0, 0, 0, 0);

        foreach (vq[vi]) begin
            for (int i = 0; i < int'(vq[vi].m) * int'(vq[vi].n) && i < 6; i++) begin
                a = vq[vi].b + 9'(i);
                mem[a] = vq[vi].vals[i];
            end
            run_check($sformatf("vec%0d", vi), vq[vi].b, vq[vi].m, vq[vi].n,
                      vq[vi].rr, vq[vi].ee, vq[vi].txt);
        end

        // ---- abort mid-row of a 3x3, then a fresh transfer ----
        for (int i = 0; i < 9; i++) mem[100 + i] = i + 1;
        drive_start(9'd100, 3'd3, 3'd3);
        k = 0;
        while (got_q.size() < 3 && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        check("abort reached_mid_row", 32'(k < 500), 32'd1);
        @(posedge clk); #1;
        en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("abort tx_valid", 32'(tx_valid), 32'd0);
        check("abort rd_en", 32'(rd_en), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("abort idle_tx_valid", 32'(tx_valid), 32'd0);
        check("abort idle_busy", 32'(busy), 32'd0);
        check("abort no_done", 32'(done_cnt), 32'd0);
        check("abort no_err", 32'(err_cnt), 32'd0);
        run_check("rerun", 9'd100, 3'd3, 3'd3, 0, 0, "1 2 3|4 5 6|7 8 9|");

        // ---- reset pulse mid-transfer ----
        for (int i = 0; i < 4; i++) mem[200 + i] = 11 * (i + 1);
        drive_start(9'd200, 3'd2, 3'd2);
        k = 0;
        while (got_q.size() < 2 && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        check("rst reached_mid_transfer", 32'(k < 500), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_async");
        @(negedge clk); #1;
        check_outputs_zero("rst_held");
        @(posedge clk); #1;
        rst = 1'b0;
        mem[20] = 405;
        run_check("after_rst", 9'd20, 3'd1, 3'd1, 0, 0, "405|");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
